// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - writeback queue with two-phase register file drain and read forwarding
module regfile_writer #(
    parameter int WIDTH = 32,
    parameter int REGNO = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    output logic                       wb_ready,
    input  logic [$clog2(REGNO)-1:0]   wb_addr,
    input  logic [WIDTH-1:0]           wb_data,
    output logic [$clog2(REGNO)-1:0]   rf_w_addr,
    output logic [WIDTH-1:0]           rf_in,
    output logic                       rf_we,
    input  logic [$clog2(REGNO)-1:0]   rd_addr_1,
    input  logic [$clog2(REGNO)-1:0]   rd_addr_2,
    output logic                       fwd_hit_1,
    output logic                       fwd_hit_2,
    output logic [WIDTH-1:0]           fwd_data_1,
    output logic [WIDTH-1:0]           fwd_data_2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(REGNO);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     addr_q [DEPTH];
    logic [WIDTH-1:0]  data_q [DEPTH];
    logic [PW-1:0]     head, tail, head_nx1;
    logic              enq, pop, load;
    logic [AW-1:0]     load_addr;
    logic [WIDTH-1:0]  load_data;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign wb_ready = !full;
    assign enq      = wb_valid && wb_ready && (wb_addr != '0);
    assign pop      = (state == STROBE);
    assign rf_we    = pop;
    assign head_nx1 = head + PW'(1);

    // The write port is loaded on entry to SETUP so address/data are stable a full
    // cycle before rf_we rises; a STROBE->SETUP hop looks past the entry being popped.
    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        load_addr = addr_q[head];
        load_data = data_q[head];
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = SETUP;
                    load     = 1'b1;
                end
            end
            SETUP: state_nx = STROBE;
            STROBE: begin
                if (count > CW'(1)) begin
                    state_nx  = SETUP;
                    load      = 1'b1;
                    load_addr = addr_q[head_nx1];
                    load_data = data_q[head_nx1];
                end else if (enq) begin
                    state_nx  = SETUP;
                    load      = 1'b1;
                    load_addr = wb_addr;
                    load_data = wb_data;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            rf_w_addr <= '0;
            rf_in     <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                rf_w_addr <= load_addr;
                rf_in     <= load_data;
            end
            if (enq)
                tail <= tail + PW'(1);
            if (pop)
                head <= head_nx1;
            case ({enq, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is qualified by head/count only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= wb_addr;
            data_q[tail] <= wb_data;
        end
    end

    function automatic logic [WIDTH:0] lookup(input logic [AW-1:0] ra);
        logic [PW-1:0] idx;
        lookup = '0;
        if (ra != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if ((CW'(i) < count) && (addr_q[idx] == ra))
                    lookup = {1'b1, data_q[idx]};
            end
        end
    endfunction

    // Later offsets from head are newer, so the last match in the scan wins.
    always_comb begin
        {fwd_hit_1, fwd_data_1} = lookup(rd_addr_1);
        {fwd_hit_2, fwd_data_2} = lookup(rd_addr_2);
    end
endmodule

// File: tb/tb_regfile_writer.sv
// tb/tb_regfile_writer.sv - directed self-checking bench for regfile_writer
module tb_regfile_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rf_w_addr;
    logic [31:0] rf_in;
    logic        rf_we;
    logic [4:0]  rd_addr_1, rd_addr_2;
    logic        fwd_hit_1, fwd_hit_2;
    logic [31:0] fwd_data_1, fwd_data_2;
    logic [2:0]  count;
    logic        empty, full;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pulses   = 0;
    logic [31:0] model [32];
    logic [36:0] cap [$];
    time         pulse_t [$];

    regfile_writer dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_w_addr(rf_w_addr), .rf_in(rf_in), .rf_we(rf_we),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    always @(posedge rf_we) begin
        pulses++;
        model[rf_w_addr] = rf_in;
        cap.push_back({rf_w_addr, rf_in});
        pulse_t.push_back($time);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (!empty && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", empty, 1'b1);
    endtask

    logic [4:0]  fa [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7};
    logic [31:0] fd [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h66, 32'h77};
    logic [4:0]  wa [10] = '{5'd9, 5'd10, 5'd11, 5'd12, 5'd9, 5'd13, 5'd14, 5'd15, 5'd10, 5'd16};

    initial begin
        int p;
        int n;
        logic [31:0] d;
        for (int i = 0; i < 32; i++) model[i] = '0;
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        rd_addr_1 = '0; rd_addr_2 = '0;
        @(negedge clk);
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_w_addr", rf_w_addr, 5'd0);
        chk("rst_rf_in", rf_in, 32'd0);
        chk("rst_wb_ready", wb_ready, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 3'd0);
        rst = 1'b0;
        step();

        // single write
        drive(5'd5, 32'hDEADBEEF);
        rd_addr_1 = 5'd5;
        chk("sw_ready", wb_ready, 1'b1);
        chk("sw_fwd_own_cycle", fwd_hit_1, 1'b0);
        step();
        wb_valid = 1'b0;
        chk("sw_count", count, 3'd1);
        chk("sw_fwd_hit", fwd_hit_1, 1'b1);
        chk("sw_fwd_data", fwd_data_1, 32'hDEADBEEF);
        chk("sw_we_e0", rf_we, 1'b0);
        step();
        chk("sw_addr_setup", rf_w_addr, 5'd5);
        chk("sw_data_setup", rf_in, 32'hDEADBEEF);
        chk("sw_we_setup", rf_we, 1'b0);
        step();
        chk("sw_we_strobe", rf_we, 1'b1);
        chk("sw_addr_strobe", rf_w_addr, 5'd5);
        chk("sw_data_strobe", rf_in, 32'hDEADBEEF);
        step();
        chk("sw_we_after", rf_we, 1'b0);
        chk("sw_empty", empty, 1'b1);
        chk("sw_fwd_gone", fwd_hit_1, 1'b0);
        chk("sw_model", model[5], 32'hDEADBEEF);
        step();
        chk("sw_idle_hold_addr", rf_w_addr, 5'd5);
        chk("sw_single_pulse", pulses, 1);

        // x0 drop
        p = pulses;
        drive(5'd0, 32'h1234);
        chk("x0_ready", wb_ready, 1'b1);
        step();
        wb_valid = 1'b0;
        chk("x0_count", count, 3'd0);
        repeat (5) step();
        chk("x0_no_pulse", pulses, p);
        chk("x0_empty", empty, 1'b1);

        // fill and backpressure
        cap.delete();
        pulse_t.delete();
        for (int i = 0; i < 5; i++) begin
            drive(fa[i], fd[i]);
            step();
        end
        chk("fill_full", full, 1'b1);
        chk("fill_ready", wb_ready, 1'b0);
        chk("fill_count", count, 3'd4);
        drive(fa[5], fd[5]);
        step();
        chk("fill_held_count", count, 3'd3);
        chk("fill_ready_again", wb_ready, 1'b1);
        step();
        wb_valid = 1'b0;
        chk("fill_count_6th", count, 3'd4);
        n = 0;
        while (cap.size() < 6 && n < 40) begin
            step();
            n++;
        end
        chk("fill_pulses", cap.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < cap.size())
                chk($sformatf("fill_order_%0d", i), cap[i], {fa[i], fd[i]});
        for (int i = 1; i < 6; i++)
            if (i < pulse_t.size())
                chk($sformatf("fill_spacing_%0d", i), pulse_t[i] - pulse_t[i-1], 20);
        wait_empty(20);

        // forwarding
        drive(5'd3, 32'hA);
        rd_addr_1 = 5'd3;
        rd_addr_2 = 5'd4;
        chk("fwd_own_cycle", fwd_hit_1, 1'b0);
        step();
        drive(5'd3, 32'hB);
        chk("fwd_first_hit", fwd_hit_1, 1'b1);
        chk("fwd_first_data", fwd_data_1, 32'hA);
        step();
        wb_valid = 1'b0;
        chk("fwd_newest_hit", fwd_hit_1, 1'b1);
        chk("fwd_newest_data", fwd_data_1, 32'hB);
        chk("fwd_miss_hit", fwd_hit_2, 1'b0);
        chk("fwd_miss_data", fwd_data_2, 32'h0);
        wait_empty(20);
        chk("fwd_drained_hit", fwd_hit_1, 1'b0);
        chk("fwd_drained_data", fwd_data_1, 32'h0);
        chk("fwd_model", model[3], 32'hB);

        // reset during STROBE
        drive(5'd20, 32'h2020);
        step();
        drive(5'd21, 32'h2121);
        step();
        wb_valid = 1'b0;
        step();
        chk("rs_we_strobe", rf_we, 1'b1);
        chk("rs_count_pre", count, 3'd2);
        #2 rst = 1'b1;
        #1;
        chk("rs_we_async", rf_we, 1'b0);
        chk("rs_count", count, 3'd0);
        chk("rs_empty", empty, 1'b1);
        chk("rs_addr", rf_w_addr, 5'd0);
        chk("rs_fwd", fwd_hit_1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        p = pulses;
        repeat (8) step();
        chk("rs_no_pulse", pulses, p);

        // wrap: sequential writes each drained before the next
        for (int k = 0; k < 10; k++) begin
            d = 32'h1000_0000 + 32'(k) * 32'h111;
            drive(wa[k], d);
            step();
            wb_valid = 1'b0;
            wait_empty(20);
            chk($sformatf("wrap_%0d", k), model[wa[k]], d);
        end
        chk("wrap_r9", model[9], 32'h1000_0444);
        chk("wrap_r10", model[10], 32'h1000_0888);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
